// File: rtl/hpi_responder.sv
// HPI slave: 1024x16 RAM behind an auto-incrementing pointer, a host-to-device mailbox and a status word.
// Optional keycode mirror of RAM byte 0x051E is enabled with HPI_RESPONDER_KEYCODE_EN.
module hpi_responder (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [1:0]  otg_hpi_address,
   input  logic        otg_hpi_cs_n,
   input  logic        otg_hpi_r_n,
   input  logic        otg_hpi_w_n,
   input  logic [15:0] otg_hpi_data_in,
   output logic [15:0] otg_hpi_data_out,
   input  logic        dev_wr,
   input  logic [9:0]  dev_addr,
   input  logic [15:0] dev_wdata,
   output logic [15:0] mbx_data,
   output logic        mbx_valid,
   input  logic        mbx_ack
`ifdef HPI_RESPONDER_KEYCODE_EN
   ,
   output logic [15:0] keycode_export
`endif
);

   localparam logic [1:0] REG_DATA = 2'd0, REG_MBX = 2'd1, REG_ADDR = 2'd2, REG_STAT = 2'd3;

   logic [15:0] ram [1024];

   logic        r_q, w_q, r_arm_q, w_arm_q;
   logic [10:0] ptr_q, ptr_d;
   logic        err_q, err_d;
   logic [15:0] mbx_data_q, mbx_data_d;
   logic        mbx_valid_q, mbx_valid_d;
   logic [15:0] dout_q, dout_d;
   logic        rd_fall, wr_fall, host_we;

   // Arm flags block a strobe still low at reset release from looking like an edge.
   assign rd_fall = r_arm_q & r_q & ~otg_hpi_r_n & ~otg_hpi_cs_n;
   assign wr_fall = w_arm_q & w_q & ~otg_hpi_w_n & ~otg_hpi_cs_n;

   always_comb begin
      ptr_d       = ptr_q;
      err_d       = err_q;
      mbx_data_d  = mbx_data_q;
      mbx_valid_d = mbx_valid_q;
      dout_d      = dout_q;
      host_we     = 1'b0;
      if (mbx_ack) mbx_valid_d = 1'b0;
      if (rd_fall && wr_fall) begin
         err_d = 1'b1;
      end else if (wr_fall) begin
         case (otg_hpi_address)
            REG_DATA: begin
               host_we = 1'b1;
               ptr_d   = ptr_q + 11'd2;
            end
            REG_MBX: begin
               mbx_data_d  = otg_hpi_data_in;
               mbx_valid_d = 1'b1;
            end
            REG_ADDR: ptr_d = {otg_hpi_data_in[10:1], 1'b0};
            default: ;
         endcase
      end else if (rd_fall) begin
         case (otg_hpi_address)
            REG_DATA: begin
               dout_d = ram[ptr_q[10:1]];
               ptr_d  = ptr_q + 11'd2;
            end
            REG_MBX:  dout_d = mbx_data_q;
            REG_ADDR: dout_d = {5'b0, ptr_q};
            default: begin
               dout_d = {14'b0, err_q, mbx_valid_q};
               err_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_q         <= 1'b1;
         w_q         <= 1'b1;
         r_arm_q     <= 1'b0;
         w_arm_q     <= 1'b0;
         ptr_q       <= '0;
         err_q       <= 1'b0;
         mbx_data_q  <= '0;
         mbx_valid_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         r_q         <= otg_hpi_r_n;
         w_q         <= otg_hpi_w_n;
         r_arm_q     <= r_arm_q | otg_hpi_r_n;
         w_arm_q     <= w_arm_q | otg_hpi_w_n;
         ptr_q       <= ptr_d;
         err_q       <= err_d;
         mbx_data_q  <= mbx_data_d;
         mbx_valid_q <= mbx_valid_d;
         dout_q      <= dout_d;
      end
   end

   // Host write is issued last so it wins a same-word collision with the device.
   always_ff @(posedge clk_clk) begin
      if (dev_wr)  ram[dev_addr]     <= dev_wdata;
      if (host_we) ram[ptr_q[10:1]] <= otg_hpi_data_in;
   end

   assign otg_hpi_data_out = dout_q;
   assign mbx_data         = mbx_data_q;
   assign mbx_valid        = mbx_valid_q;

`ifdef HPI_RESPONDER_KEYCODE_EN
   localparam logic [9:0] KEY_WORD = 10'h28F;
   logic [15:0] kc_q, kc_d;

   always_comb begin
      kc_d = kc_q;
      if (host_we && ptr_q[10:1] == KEY_WORD) kc_d = otg_hpi_data_in;
      else if (dev_wr && dev_addr == KEY_WORD) kc_d = dev_wdata;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) kc_q <= '0;
      else                kc_q <= kc_d;
   end

   assign keycode_export = kc_q;
`endif

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: vector table for register traffic plus hand sequences for corner cases.
module tb_hpi_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  addr = '0;
   logic        cs_n = 1'b1, r_n = 1'b1, w_n = 1'b1;
   logic [15:0] din = '0;
   logic [15:0] dout;
   logic        dev_wr = 1'b0;
   logic [9:0]  dev_addr = '0;
   logic [15:0] dev_wdata = '0;
   logic [15:0] mbx_data;
   logic        mbx_valid;
   logic        mbx_ack = 1'b0;
`ifdef HPI_RESPONDER_KEYCODE_EN
   logic [15:0] keycode;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;

   hpi_responder dut (
      .clk_clk(clk), .reset_reset_n(rst_n),
      .otg_hpi_address(addr), .otg_hpi_cs_n(cs_n), .otg_hpi_r_n(r_n), .otg_hpi_w_n(w_n),
      .otg_hpi_data_in(din), .otg_hpi_data_out(dout),
      .dev_wr(dev_wr), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
      .mbx_data(mbx_data), .mbx_valid(mbx_valid), .mbx_ack(mbx_ack)
`ifdef HPI_RESPONDER_KEYCODE_EN
      , .keycode_export(keycode)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  a;
      logic [15:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [18];

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%04h want 0x%04h", nm, act, exp);
      end
   endtask

   task automatic hwrite(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      addr = a; din = d; cs_n = 1'b0; w_n = 1'b0;
      @(negedge clk);
      w_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic hread(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a; cs_n = 1'b0; r_n = 1'b0;
      @(negedge clk);
      d = dout;
      r_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
   endtask

   logic [15:0] rd;

   initial begin
      // wr, addr, wdata, expected read (write rows ignore exp)
      tbl[0]  = '{1'b1, A_ADDR, 16'h0100, 16'h0};
      tbl[1]  = '{1'b1, A_DATA, 16'hAAAA, 16'h0};
      tbl[2]  = '{1'b1, A_DATA, 16'h5555, 16'h0};
      tbl[3]  = '{1'b1, A_ADDR, 16'h0100, 16'h0};
      tbl[4]  = '{1'b0, A_DATA, 16'h0,    16'hAAAA};
      tbl[5]  = '{1'b0, A_DATA, 16'h0,    16'h5555};
      tbl[6]  = '{1'b0, A_ADDR, 16'h0,    16'h0104};
      tbl[7]  = '{1'b1, A_ADDR, 16'h07FE, 16'h0};
      tbl[8]  = '{1'b1, A_DATA, 16'h1234, 16'h0};
      tbl[9]  = '{1'b0, A_ADDR, 16'h0,    16'h0000};
      tbl[10] = '{1'b1, A_ADDR, 16'h07FE, 16'h0};
      tbl[11] = '{1'b0, A_DATA, 16'h0,    16'h1234};
      tbl[12] = '{1'b0, A_ADDR, 16'h0,    16'h0000};
      tbl[13] = '{1'b1, A_ADDR, 16'hF803, 16'h0};
      tbl[14] = '{1'b0, A_ADDR, 16'h0,    16'h0002};
      tbl[15] = '{1'b1, A_STAT, 16'hFFFF, 16'h0};
      tbl[16] = '{1'b0, A_STAT, 16'h0,    16'h0000};
      tbl[17] = '{1'b0, A_ADDR, 16'h0,    16'h0002};

      repeat (3) @(negedge clk);
      check("reset_dout", dout, 16'h0);
      check("reset_mbx_data", mbx_data, 16'h0);
      check("reset_mbx_valid", {15'b0, mbx_valid}, 16'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 18; i++) begin
         if (tbl[i].wr) hwrite(tbl[i].a, tbl[i].d);
         else begin
            hread(tbl[i].a, rd);
            check($sformatf("vec%0d", i), rd, tbl[i].exp);
         end
      end

      // Mailbox: write, status, ack, then ack coincident with a write.
      hwrite(A_MBX, 16'hBEEF);
      check("mbx_valid_set", {15'b0, mbx_valid}, 16'h1);
      check("mbx_data_port", mbx_data, 16'hBEEF);
      hread(A_STAT, rd);  check("status_mbx", rd, 16'h0001);
      hread(A_MBX, rd);   check("mbx_read", rd, 16'hBEEF);
      @(negedge clk); mbx_ack = 1'b1;
      @(negedge clk); mbx_ack = 1'b0;
      hread(A_STAT, rd);  check("status_acked", rd, 16'h0000);
      @(negedge clk);
      addr = A_MBX; din = 16'h0001; cs_n = 1'b0; w_n = 1'b0; mbx_ack = 1'b1;
      @(negedge clk);
      mbx_ack = 1'b0; w_n = 1'b1; cs_n = 1'b1;
      check("ack_vs_write_valid", {15'b0, mbx_valid}, 16'h1);
      check("ack_vs_write_data", mbx_data, 16'h0001);
      @(negedge clk); mbx_ack = 1'b1;
      @(negedge clk); mbx_ack = 1'b0;

      // Simultaneous r_n/w_n fall: error, no access, pointer frozen.
      hwrite(A_ADDR, 16'h0200);
      @(negedge clk);
      addr = A_DATA; din = 16'h9999; cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0;
      @(negedge clk);
      r_n = 1'b1; w_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
      hread(A_ADDR, rd);  check("err_ptr_frozen", rd, 16'h0200);
      hread(A_STAT, rd);  check("status_err", rd, 16'h0002);
      hread(A_STAT, rd);  check("status_err_clr", rd, 16'h0000);

      // Read data holds across non-read traffic.
      hread(A_ADDR, rd);
      hwrite(A_MBX, 16'h7777);
      repeat (2) @(negedge clk);
      check("dout_hold", dout, 16'h0200);
      @(negedge clk); mbx_ack = 1'b1;
      @(negedge clk); mbx_ack = 1'b0;

      // Strobes ignored with cs_n high.
      @(negedge clk);
      addr = A_DATA; din = 16'h4444; w_n = 1'b0;
      @(negedge clk); w_n = 1'b1;
      @(negedge clk);
      hread(A_ADDR, rd);  check("cs_high_ignored", rd, 16'h0200);

      // cs_n rising mid-strobe keeps the captured write.
      @(negedge clk);
      addr = A_DATA; din = 16'h6666; cs_n = 1'b0; w_n = 1'b0;
      @(negedge clk); cs_n = 1'b1;
      @(negedge clk); w_n = 1'b1;
      @(negedge clk);
      hwrite(A_ADDR, 16'h0200);
      hread(A_DATA, rd);  check("cs_rise_midstrobe", rd, 16'h6666);

      // Device writes and same-word collision.
      @(negedge clk); dev_wr = 1'b1; dev_addr = 10'h010; dev_wdata = 16'hCAFE;
      @(negedge clk); dev_wr = 1'b0;
      hwrite(A_ADDR, 16'h0020);
      hread(A_DATA, rd);  check("dev_write", rd, 16'hCAFE);
      hwrite(A_ADDR, 16'h0020);
      @(negedge clk);
      addr = A_DATA; din = 16'h2222; cs_n = 1'b0; w_n = 1'b0;
      dev_wr = 1'b1; dev_addr = 10'h010; dev_wdata = 16'h1111;
      @(negedge clk);
      dev_wr = 1'b0; w_n = 1'b1; cs_n = 1'b1;
      hwrite(A_ADDR, 16'h0020);
      hread(A_DATA, rd);  check("collision_host_wins", rd, 16'h2222);

`ifdef HPI_RESPONDER_KEYCODE_EN
      check("keycode_reset", keycode, 16'h0);
      @(negedge clk); dev_wr = 1'b1; dev_addr = 10'h28F; dev_wdata = 16'h0004;
      @(negedge clk); dev_wr = 1'b0;
      check("keycode_dev", keycode, 16'h0004);
      hwrite(A_ADDR, 16'h051E);
      @(negedge clk);
      addr = A_DATA; din = 16'h0007; cs_n = 1'b0; w_n = 1'b0;
      dev_wr = 1'b1; dev_addr = 10'h28F; dev_wdata = 16'h0009;
      @(negedge clk);
      dev_wr = 1'b0; w_n = 1'b1; cs_n = 1'b1;
      check("keycode_host_wins", keycode, 16'h0007);
`endif

      // Reset mid-read with r_n held low: no phantom read after release.
      @(negedge clk); dev_wr = 1'b1; dev_addr = 10'h000; dev_wdata = 16'hA5A5;
      @(negedge clk); dev_wr = 1'b0;
      hwrite(A_ADDR, 16'h0000);
      hwrite(A_MBX, 16'h3C3C);
      @(negedge clk);
      addr = A_DATA; cs_n = 1'b0; r_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 16'h0);
      check("rst_mbx_data", mbx_data, 16'h0);
      check("rst_mbx_valid", {15'b0, mbx_valid}, 16'h0);
`ifdef HPI_RESPONDER_KEYCODE_EN
      check("rst_keycode", keycode, 16'h0);
`endif
      r_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
      hread(A_DATA, rd);  check("post_rst_read", rd, 16'hA5A5);
      hread(A_ADDR, rd);  check("post_rst_ptr", rd, 16'h0002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
